// File: rtl/xb_fwd_if.sv
// Bus bundle between the compute-unit write-back sources, the register file
// and the xb_fwd crossbar. The crossbar connects on the slave side.
interface xb_fwd_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 4,
  parameter int NUM_SRC       = 4,
  parameter int NUM_RD        = 2
);
  logic                              ps_xb_stall;
  logic [NUM_SRC-1:0]                ps_xb_w_En;
  logic [ADDRESS_WIDTH-1:0]          ps_xb_wadd;
  logic [NUM_RD*ADDRESS_WIDTH-1:0]   ps_xb_radd;
  logic [NUM_SRC*DATA_WIDTH-1:0]     src_xb_dt;
  logic [NUM_RD*DATA_WIDTH-1:0]      rf_xb_dt;
  logic [NUM_RD*DATA_WIDTH-1:0]      xb_dt;
  logic                              xb_rf_w_En;
  logic [ADDRESS_WIDTH-1:0]          xb_rf_wadd;
  logic [DATA_WIDTH-1:0]             xb_rf_dt;
  logic                              xb_err;
  logic [7:0]                        xb_err_cnt;

  modport master (
    output ps_xb_stall, ps_xb_w_En, ps_xb_wadd, ps_xb_radd, src_xb_dt, rf_xb_dt,
    input  xb_dt, xb_rf_w_En, xb_rf_wadd, xb_rf_dt, xb_err, xb_err_cnt
  );

  modport slave (
    input  ps_xb_stall, ps_xb_w_En, ps_xb_wadd, ps_xb_radd, src_xb_dt, rf_xb_dt,
    output xb_dt, xb_rf_w_En, xb_rf_wadd, xb_rf_dt, xb_err, xb_err_cnt
  );
endinterface

// File: rtl/xb_fwd.sv
// Write-back crossbar with registered RF write, FWD_DEPTH-deep write history
// for operand forwarding, and multi-source conflict detection.
module xb_fwd #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 4,
  parameter int NUM_SRC       = 4,
  parameter int NUM_RD        = 2,
  parameter int FWD_DEPTH     = 2
) (
  input logic     clk_dcd,
  input logic     rst_n,
  xb_fwd_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDRESS_WIDTH;

  logic                   lv;
  logic [DW-1:0]          ld;
  logic                   conflict;

  logic                   wb_vld_p0;
  logic [AW-1:0]          wb_addr_p0;
  logic [DW-1:0]          wb_dt_p0;

  logic [FWD_DEPTH-1:0]   hist_vld;
  logic [AW-1:0]          hist_addr [FWD_DEPTH];
  logic [DW-1:0]          hist_dt   [FWD_DEPTH];

  logic                   err_q;
  logic [7:0]             err_cnt_q;

  logic [AW-1:0]          rd_addr;
  logic [DW-1:0]          rd_fwd;
  logic [NUM_RD*DW-1:0]   xb_dt_c;

  // Source select: descending scan so the lowest set index wins.
  always_comb begin
    ld = '0;
    for (int s = NUM_SRC - 1; s >= 0; s--) begin
      if (bus.ps_xb_w_En[s]) ld = bus.src_xb_dt[s*DW +: DW];
    end
    lv       = (|bus.ps_xb_w_En) & ~bus.ps_xb_stall;
    conflict = ((bus.ps_xb_w_En & (bus.ps_xb_w_En - NUM_SRC'(1))) != '0) & ~bus.ps_xb_stall;
  end

  // Stage p0: registered write-back and history shift, both frozen on stall.
  always_ff @(posedge clk_dcd or negedge rst_n) begin
    if (!rst_n) begin
      wb_vld_p0  <= 1'b0;
      wb_addr_p0 <= '0;
      wb_dt_p0   <= '0;
      hist_vld   <= '0;
      for (int k = 0; k < FWD_DEPTH; k++) begin
        hist_addr[k] <= '0;
        hist_dt[k]   <= '0;
      end
    end else if (!bus.ps_xb_stall) begin
      wb_vld_p0 <= lv;
      if (lv) begin
        wb_addr_p0 <= bus.ps_xb_wadd;
        wb_dt_p0   <= ld;
      end
      for (int k = FWD_DEPTH - 1; k >= 1; k--) begin
        hist_vld[k]  <= hist_vld[k-1];
        hist_addr[k] <= hist_addr[k-1];
        hist_dt[k]   <= hist_dt[k-1];
      end
      hist_vld[0]  <= lv;
      hist_addr[0] <= bus.ps_xb_wadd;
      hist_dt[0]   <= ld;
    end else begin
      wb_vld_p0 <= 1'b0;
    end
  end

  always_ff @(posedge clk_dcd or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else if (conflict) begin
      err_q <= 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  // Forwarding: oldest candidates applied first so younger ones overwrite.
  always_comb begin
    rd_addr = '0;
    rd_fwd  = '0;
    xb_dt_c = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      rd_addr = bus.ps_xb_radd[r*AW +: AW];
      rd_fwd  = bus.rf_xb_dt[r*DW +: DW];
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
        if (hist_vld[k] && hist_addr[k] == rd_addr) rd_fwd = hist_dt[k];
      end
      if (lv && bus.ps_xb_wadd == rd_addr) rd_fwd = ld;
      xb_dt_c[r*DW +: DW] = rd_fwd;
    end
  end

  assign bus.xb_dt      = xb_dt_c;
  assign bus.xb_rf_w_En = wb_vld_p0;
  assign bus.xb_rf_wadd = wb_addr_p0;
  assign bus.xb_rf_dt   = wb_dt_p0;
  assign bus.xb_err     = err_q;
  assign bus.xb_err_cnt = err_cnt_q;
endmodule
